fxp_calc: RTL and testbench

//  Configurable two-operand adder for the perceptron datapath, handling integer (INT) and

---
 rtl/fxp_calc_if.sv | 26 ++
 rtl/fxp_calc.sv | 85 ++++++++
 tb/tb_fxp_calc.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fxp_calc_if.sv
// Operand/result bundle for fxp_calc: one valid-qualified operand pair in, one registered result out.
// Valid-only flow: no ready; a pair is consumed on every edge where in_valid=1, and out_valid marks the result one cycle later.
interface fxp_calc_if #(
    parameter int I1_PREC = 8,
    parameter int I2_PREC = 8,
    parameter int O_PREC  = 8
) ();
    logic               in_valid;
    logic [I1_PREC-1:0] in1;
    logic [I2_PREC-1:0] in2;
    logic               out_valid;
    logic [O_PREC-1:0]  out;
    logic               ovf;
    logic               udf;
    logic               rounded;

    modport master (
        output in_valid, in1, in2,
        input  out_valid, out, ovf, udf, rounded
    );

    modport slave (
        input  in_valid, in1, in2,
        output out_valid, out, ovf, udf, rounded
    );
endinterface

// File: rtl/fxp_calc.sv
// Two-operand INT/FXP adder: aligns binary points, adds exactly, converts to the output
// format with floor rounding and saturation, and registers the result (latency 1).
module fxp_calc #(
    parameter int TYPE    = 0,
    parameter int I1_SIGN = 1,
    parameter int I1_PREC = 8,
    parameter int I1_FRAC = 0,
    parameter int I2_SIGN = 1,
    parameter int I2_PREC = 8,
    parameter int I2_FRAC = 0,
    parameter int O_SIGN  = ((I1_SIGN != 0) || (I2_SIGN != 0)) ? 1 : 0,
    parameter int O_PREC  = (I1_PREC > I2_PREC) ? I1_PREC : I2_PREC,
    parameter int O_FRAC  = (I1_FRAC > I2_FRAC) ? I1_FRAC : I2_FRAC
) (
    input logic        clk,
    input logic        reset,
    fxp_calc_if.slave  bus
);
    // INT mode treats every format as having no fraction bits
    localparam int EF1 = (TYPE == 1) ? I1_FRAC : 0;
    localparam int EF2 = (TYPE == 1) ? I2_FRAC : 0;
    localparam int EFO = (TYPE == 1) ? O_FRAC  : 0;
    localparam int F   = (EF1 > EF2) ? EF1 : EF2;
    localparam int IW1 = I1_PREC - EF1;
    localparam int IW2 = I2_PREC - EF2;
    localparam int W   = ((IW1 > IW2) ? IW1 : IW2) + F + 2;
    localparam int SH1 = F - EF1;
    localparam int SH2 = F - EF2;
    localparam int RS  = (F > EFO) ? (F - EFO) : 0;
    localparam int LS  = (EFO > F) ? (EFO - F) : 0;
    // Range-check width holds the left-shifted sum and both output limits with headroom
    localparam int CW  = (((W + LS) > O_PREC) ? (W + LS) : O_PREC) + 2;

    localparam logic signed [CW-1:0] MAXV = (CW'(1) <<< (O_PREC - O_SIGN)) - CW'(1);
    localparam logic signed [CW-1:0] MINV = (O_SIGN != 0) ? -(CW'(1) <<< (O_PREC - 1)) : '0;

    logic                     s1, s2;
    logic signed [W-1:0]      ext1, ext2, a1, a2, sum, q;
    logic signed [CW-1:0]     cv;
    logic [O_PREC-1:0]        nxt_out;
    logic                     nxt_ovf, nxt_udf, nxt_rnd;

    assign s1 = (I1_SIGN != 0) ? bus.in1[I1_PREC-1] : 1'b0;
    assign s2 = (I2_SIGN != 0) ? bus.in2[I2_PREC-1] : 1'b0;

    always_comb begin
        ext1    = {{(W-I1_PREC){s1}}, bus.in1};
        ext2    = {{(W-I2_PREC){s2}}, bus.in2};
        a1      = ext1 <<< SH1;
        a2      = ext2 <<< SH2;
        sum     = a1 + a2;
        // Arithmetic right shift floors toward -inf; any lost bit makes the shift non-reversible
        q       = sum >>> RS;
        nxt_rnd = ((q <<< RS) != sum);
        cv      = CW'(q) <<< LS;
        nxt_out = cv[O_PREC-1:0];
        nxt_ovf = 1'b0;
        nxt_udf = 1'b0;
        if (cv > MAXV) begin
            nxt_out = MAXV[O_PREC-1:0];
            nxt_ovf = 1'b1;
        end else if (cv < MINV) begin
            nxt_out = MINV[O_PREC-1:0];
            nxt_udf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.ovf       <= 1'b0;
            bus.udf       <= 1'b0;
            bus.rounded   <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out     <= nxt_out;
                bus.ovf     <= nxt_ovf;
                bus.udf     <= nxt_udf;
                bus.rounded <= nxt_rnd;
            end
        end
    end
endmodule

// File: tb/tb_fxp_calc.sv
// Bench for fxp_calc across four formats: INT signed, FXP s8.3+s16.4->s16.4,
// FXP s8.4+s8.4->s8.2, and INT unsigned+signed->unsigned.
module tb_fxp_calc;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fxp_calc_if #(.I1_PREC(8), .I2_PREC(8),  .O_PREC(8))  ia ();
    fxp_calc_if #(.I1_PREC(8), .I2_PREC(16), .O_PREC(16)) ib ();
    fxp_calc_if #(.I1_PREC(8), .I2_PREC(8),  .O_PREC(8))  ic ();
    fxp_calc_if #(.I1_PREC(8), .I2_PREC(8),  .O_PREC(8))  id ();

    fxp_calc u_a (.clk(clk), .reset(reset), .bus(ia));

    fxp_calc #(
        .TYPE(1), .I1_SIGN(1), .I1_PREC(8), .I1_FRAC(3),
        .I2_SIGN(1), .I2_PREC(16), .I2_FRAC(4),
        .O_SIGN(1), .O_PREC(16), .O_FRAC(4)
    ) u_b (.clk(clk), .reset(reset), .bus(ib));

    fxp_calc #(
        .TYPE(1), .I1_SIGN(1), .I1_PREC(8), .I1_FRAC(4),
        .I2_SIGN(1), .I2_PREC(8), .I2_FRAC(4),
        .O_SIGN(1), .O_PREC(8), .O_FRAC(2)
    ) u_c (.clk(clk), .reset(reset), .bus(ic));

    fxp_calc #(
        .TYPE(0), .I1_SIGN(0), .I1_PREC(8), .I1_FRAC(0),
        .I2_SIGN(1), .I2_PREC(8), .I2_FRAC(0),
        .O_SIGN(0), .O_PREC(8), .O_FRAC(0)
    ) u_d (.clk(clk), .reset(reset), .bus(id));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic longint interp(input logic [15:0] raw, input int prec, input bit sgn);
        longint v;
        v = longint'(raw) & ((longint'(1) << prec) - 1);
        if (sgn && raw[prec-1]) v = v - (longint'(1) << prec);
        return v;
    endfunction

    // True sum in units of 2^-f, floored to 2^-fo, then clamped to the output range
    function automatic logic [19:0] model(input longint v1, input longint v2,
                                          input int f1, input int f2, input int fo,
                                          input int oprec, input bit osign);
        int     f;
        longint s, d, q, mx, mn, o;
        bit     ov, ud, rd;
        logic [63:0] raw;
        f  = (f1 > f2) ? f1 : f2;
        s  = v1 * (longint'(1) << (f - f1)) + v2 * (longint'(1) << (f - f2));
        rd = 1'b0;
        if (fo < f) begin
            d = longint'(1) << (f - fo);
            q = s / d;
            if (q * d != s) begin
                rd = 1'b1;
                if (s < 0) q = q - 1;
            end
        end else begin
            q = s * (longint'(1) << (fo - f));
        end
        mx = (longint'(1) << (oprec - (osign ? 1 : 0))) - 1;
        mn = osign ? -(longint'(1) << (oprec - 1)) : 0;
        ov = (q > mx);
        ud = (q < mn);
        o  = ov ? mx : (ud ? mn : q);
        raw = 64'(o) & ((64'd1 << oprec) - 64'd1);
        return {1'b1, ov, ud, rd, raw[15:0]};
    endfunction

    function automatic logic [19:0] pk(input bit v, input bit ov, input bit ud, input bit rd,
                                       input logic [15:0] o);
        return {v, ov, ud, rd, o};
    endfunction

    function automatic logic [19:0] obs(input int dut);
        logic [19:0] r;
        r = '0;
        case (dut)
            0: r = {ia.out_valid, ia.ovf, ia.udf, ia.rounded, 8'h00, ia.out};
            1: r = {ib.out_valid, ib.ovf, ib.udf, ib.rounded, ib.out};
            2: r = {ic.out_valid, ic.ovf, ic.udf, ic.rounded, 8'h00, ic.out};
            default: r = {id.out_valid, id.ovf, id.udf, id.rounded, 8'h00, id.out};
        endcase
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int dut, input logic v, input logic [15:0] x, input logic [15:0] y);
        case (dut)
            0: begin ia.in_valid = v; ia.in1 = x[7:0]; ia.in2 = y[7:0]; end
            1: begin ib.in_valid = v; ib.in1 = x[7:0]; ib.in2 = y;      end
            2: begin ic.in_valid = v; ic.in1 = x[7:0]; ic.in2 = y[7:0]; end
            default: begin id.in_valid = v; id.in1 = x[7:0]; id.in2 = y[7:0]; end
        endcase
    endtask

    // Apply one input cycle; on return the registered result is observable
    task automatic step(input int dut, input logic v, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        drive(dut, v, x, y);
        @(negedge clk);
        drive(dut, 1'b0, x, y);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [19:0] got;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) drive(k, 1'b0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            got = obs(k);
            checks++;
            if (got !== 20'h0) begin
                failures++;
                $display("FAIL reset dut=%0d got=%h exp=%h", k, got, 20'h0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_int_basic();
        logic [19:0] got, exp;
        step(0, 1'b1, 16'd3, 16'd2);
        got = obs(0); exp = pk(1, 0, 0, 0, 16'h0005);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL int_add got=%h exp=%h", got, exp); end
    endtask

    task automatic test_int_saturate();
        logic [19:0] got, exp;
        step(0, 1'b1, 16'd100, 16'd100);
        got = obs(0); exp = pk(1, 1, 0, 0, 16'h007F);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL int_ovf got=%h exp=%h", got, exp); end
        step(0, 1'b1, 16'h009C, 16'h009C);
        got = obs(0); exp = pk(1, 0, 1, 0, 16'h0080);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL int_udf got=%h exp=%h", got, exp); end
        step(0, 1'b1, 16'h007F, 16'h0000);
        got = obs(0); exp = pk(1, 0, 0, 0, 16'h007F);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL int_max_exact got=%h exp=%h", got, exp); end
    endtask

    task automatic test_hold();
        logic [19:0] got, exp;
        step(0, 1'b1, 16'd100, 16'd100);
        step(0, 1'b0, 16'd1, 16'd1);
        got = obs(0); exp = pk(0, 1, 0, 0, 16'h007F);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL hold got=%h exp=%h", got, exp); end
        step(0, 1'b1, 16'd1, 16'd1);
        got = obs(0); exp = pk(1, 0, 0, 0, 16'h0002);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL flag_clear got=%h exp=%h", got, exp); end
    endtask

    task automatic test_fxp_align();
        logic [19:0] got, exp;
        step(1, 1'b1, 16'h001C, 16'h0020);
        got = obs(1); exp = pk(1, 0, 0, 0, 16'h0058);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL fxp_align_a got=%h exp=%h", got, exp); end
        step(1, 1'b1, 16'h007C, 16'h01F2);
        got = obs(1); exp = pk(1, 0, 0, 0, 16'h02EA);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL fxp_align_b got=%h exp=%h", got, exp); end
    endtask

    task automatic test_fxp_round();
        logic [19:0] got, exp;
        step(2, 1'b1, 16'h0001, 16'h0000);
        got = obs(2); exp = pk(1, 0, 0, 1, 16'h0000);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL round_pos got=%h exp=%h", got, exp); end
        step(2, 1'b1, 16'h0000, 16'h0004);
        got = obs(2); exp = pk(1, 0, 0, 0, 16'h0001);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL round_exact got=%h exp=%h", got, exp); end
        step(2, 1'b1, 16'h00FF, 16'h0000);
        got = obs(2); exp = pk(1, 0, 0, 1, 16'h00FF);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL round_neg_floor got=%h exp=%h", got, exp); end
    endtask

    task automatic test_unsigned();
        logic [19:0] got, exp;
        step(3, 1'b1, 16'd200, 16'd100);
        got = obs(3); exp = pk(1, 1, 0, 0, 16'h00FF);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL uns_ovf got=%h exp=%h", got, exp); end
        step(3, 1'b1, 16'd3, 16'h00FB);
        got = obs(3); exp = pk(1, 0, 1, 0, 16'h0000);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL uns_udf got=%h exp=%h", got, exp); end
        step(3, 1'b1, 16'd250, 16'h00F6);
        got = obs(3); exp = pk(1, 0, 0, 0, 16'h00F0);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL uns_zext got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_midstream();
        logic [19:0] got;
        step(0, 1'b1, 16'd100, 16'd100);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b1, 16'd3, 16'd2);
        @(negedge clk);
        got = obs(0);
        checks++;
        if (got !== 20'h0) begin failures++; $display("FAIL reset_mid got=%h exp=%h", got, 20'h0); end
        reset = 1'b0;
        drive(0, 1'b0, 16'd0, 16'd0);
    endtask

    // Back-to-back random pairs; expected results queue up one cycle ahead of the DUT
    task automatic test_back_to_back(input int dut, input int n);
        logic [19:0] exp_q[$];
        logic [19:0] got, exp;
        logic [15:0] x, y;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got = obs(dut);
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hFFFFF;
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL rand dut=%0d idx=%0d got=%h exp=%h", dut, i - 1, got, exp);
                end
            end
            if (i < n) begin
                x = 16'($urandom_range(0, 255));
                y = (dut == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 255));
                case (dut)
                    0: exp_q.push_back(model(interp(x, 8, 1), interp(y, 8, 1), 0, 0, 0, 8, 1));
                    1: exp_q.push_back(model(interp(x, 8, 1), interp(y, 16, 1), 3, 4, 4, 16, 1));
                    2: exp_q.push_back(model(interp(x, 8, 1), interp(y, 8, 1), 4, 4, 2, 8, 1));
                    default: exp_q.push_back(model(interp(x, 8, 0), interp(y, 8, 1), 0, 0, 0, 8, 0));
                endcase
                drive(dut, 1'b1, x, y);
            end else begin
                drive(dut, 1'b0, 16'h0, 16'h0);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_int_basic();
        test_int_saturate();
        test_hold();
        test_fxp_align();
        test_fxp_round();
        test_unsigned();
        test_reset_midstream();
        test_back_to_back(0, 250);
        test_back_to_back(1, 250);
        test_back_to_back(2, 250);
        test_back_to_back(3, 250);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
